// File: rtl/alu_issue_wb.sv
// alu_issue_wb: issues one MIPS instruction at a time to an external
// combinational ALU and retires its result to the rf or HI/LO.
module alu_issue_wb #(
   parameter int NREG = 32,
   parameter int W    = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         instr_valid,
   input  logic [W-1:0] instr,
   output logic         instr_ready,
   output logic [W-1:0] alu_instr,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   input  logic [W-1:0] alu_c,
   input  logic [2:0]   alu_zon,
   input  logic [W-1:0] alu_hi,
   input  logic [W-1:0] alu_lo,
   output logic         wb_valid,
   output logic         wb_we,
   output logic [4:0]   wb_addr,
   output logic [W-1:0] wb_data,
   output logic [W-1:0] hi_q,
   output logic [W-1:0] lo_q,
   output logic [2:0]   flags_q,
   output logic         branch_taken,
   input  logic         dbg_we,
   input  logic [4:0]   dbg_addr,
   input  logic [W-1:0] dbg_wdata,
   output logic [W-1:0] dbg_rdata
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t       state, state_nx;
   logic [W-1:0] rf [NREG];
   logic [W-1:0] res_c, res_hi, res_lo;
   logic         accept, dbg_take;
   logic [5:0]   op, fn;
   logic         r_op, div_ok;
   logic         k_alu, k_imm, k_md, k_div0;
   logic         k_mfhi, k_mflo, k_beq, k_bne;
   logic [4:0]   dst;
   logic         wr_dst, flag_upd;

   assign instr_ready = (state == IDLE);
   assign accept      = instr_ready && instr_valid;
   assign dbg_take    = instr_ready && !instr_valid &&
                        dbg_we && (dbg_addr != 5'd0);

   assign op     = alu_instr[31:26];
   assign fn     = alu_instr[5:0];
   assign r_op   = (op == 6'h00);
   assign div_ok = |alu_b;

   // decode is taken from the latched word, stable through EXEC and WB
   always_comb begin
      k_alu  = 1'b0;
      k_imm  = 1'b0;
      k_md   = 1'b0;
      k_div0 = 1'b0;
      k_mfhi = 1'b0;
      k_mflo = 1'b0;
      k_beq  = 1'b0;
      k_bne  = 1'b0;
      unique case (1'b1)
         r_op && (fn inside {6'h20, 6'h21, 6'h22, 6'h23,
                             6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2a, 6'h2b, 6'h00, 6'h02,
                             6'h03, 6'h04, 6'h06, 6'h07}):
            k_alu = 1'b1;
         r_op && (fn inside {6'h18, 6'h19}):
            k_md = 1'b1;
         r_op && (fn inside {6'h1a, 6'h1b}): begin
            k_md   = div_ok;
            k_div0 = !div_ok;
         end
         r_op && (fn == 6'h10):
            k_mfhi = 1'b1;
         r_op && (fn == 6'h12):
            k_mflo = 1'b1;
         op inside {[6'h08:6'h0e]}:
            k_imm = 1'b1;
         op == 6'h04:
            k_beq = 1'b1;
         op == 6'h05:
            k_bne = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (instr_valid) state_nx = EXEC;
         EXEC:    state_nx = WB;
         WB:      state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign dst = k_imm ? alu_instr[20:16] :
                (k_alu || k_mfhi || k_mflo) ?
                alu_instr[15:11] : 5'd0;
   assign wr_dst   = (k_alu || k_imm || k_mfhi || k_mflo) &&
                     (dst != 5'd0);
   assign flag_upd = !(k_mfhi || k_mflo || k_div0);

   assign wb_valid = (state == WB);
   assign wb_we    = wb_valid && wr_dst;
   assign wb_addr  = wb_valid ? dst : 5'd0;
   assign wb_data  = !wb_valid ? '0 :
                     k_mfhi ? hi_q :
                     k_mflo ? lo_q : res_c;

   // the zero flag captured at EXEC carries the compare result
   assign branch_taken = wb_valid &&
                         ((k_beq && flags_q[2]) ||
                          (k_bne && !flags_q[2]));

   assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : rf[dbg_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         alu_instr <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         res_c     <= '0;
         res_hi    <= '0;
         res_lo    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         flags_q   <= '0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            alu_instr <= instr;
            alu_a     <= rf[instr[25:21]];
            alu_b     <= rf[instr[20:16]];
         end
         if (state == EXEC) begin
            res_c  <= alu_c;
            res_hi <= alu_hi;
            res_lo <= alu_lo;
            if (flag_upd) flags_q <= alu_zon;
         end
         if (state == WB) begin
            if (k_md) begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            if (wr_dst) rf[dst] <= wb_data;
         end
         if (dbg_take) rf[dbg_addr] <= dbg_wdata;
      end
   end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb_alu_issue_wb: ALU stub plus architectural model; directed
// plan cases followed by randomized instruction streams.
module tb_alu_issue_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [31:0] alu_instr, alu_a, alu_b;
   logic [31:0] alu_c, alu_hi, alu_lo;
   logic [2:0]  alu_zon;
   logic        wb_valid, wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, hi_q, lo_q;
   logic [2:0]  flags_q;
   logic        branch_taken;
   logic        dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata, dbg_rdata;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_issue_wb dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready),
      .alu_instr(alu_instr), .alu_a(alu_a), .alu_b(alu_b),
      .alu_c(alu_c), .alu_zon(alu_zon),
      .alu_hi(alu_hi), .alu_lo(alu_lo),
      .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_addr(wb_addr), .wb_data(wb_data),
      .hi_q(hi_q), .lo_q(lo_q), .flags_q(flags_q),
      .branch_taken(branch_taken),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
   );

   // behavioural MIPS ALU standing in for the real combinational unit
   function automatic void alu_fn(
      input  logic [31:0] ins, a, b,
      output logic [31:0] c,
      output logic [2:0]  zon,
      output logic [31:0] hi, lo);
      logic [5:0]  op, fn;
      logic [4:0]  sh;
      logic [31:0] si, zi;
      logic        ov;
      logic [63:0] p;
      op = ins[31:26];
      fn = ins[5:0];
      sh = ins[10:6];
      si = {{16{ins[15]}}, ins[15:0]};
      zi = {16'd0, ins[15:0]};
      c = 0; hi = 0; lo = 0; ov = 0; p = 0;
      if (op == 6'h00) begin
         case (fn)
            6'h20, 6'h21: begin
               c = a + b;
               ov = fn == 6'h20 && a[31] == b[31] &&
                    c[31] != a[31];
            end
            6'h22, 6'h23: begin
               c = a - b;
               ov = fn == 6'h22 && a[31] != b[31] &&
                    c[31] != a[31];
            end
            6'h24: c = a & b;
            6'h25: c = a | b;
            6'h26: c = a ^ b;
            6'h27: c = ~(a | b);
            6'h2a: c = {31'd0, $signed(a) < $signed(b)};
            6'h2b: c = {31'd0, a < b};
            6'h00: c = b << sh;
            6'h02: c = b >> sh;
            6'h03: c = $signed(b) >>> sh;
            6'h04: c = b << a[4:0];
            6'h06: c = b >> a[4:0];
            6'h07: c = $signed(b) >>> a[4:0];
            6'h18: begin
               p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
               hi = p[63:32]; lo = p[31:0];
            end
            6'h19: begin
               p = {32'd0, a} * {32'd0, b};
               hi = p[63:32]; lo = p[31:0];
            end
            6'h1a: if (b != 0) begin
               if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                  lo = a; hi = 0;
               end else begin
                  lo = $signed(a) / $signed(b);
                  hi = $signed(a) % $signed(b);
               end
            end
            6'h1b: if (b != 0) begin
               lo = a / b; hi = a % b;
            end
            default: ;
         endcase
      end else begin
         case (op)
            6'h08, 6'h09: begin
               c = a + si;
               ov = op == 6'h08 && a[31] == si[31] &&
                    c[31] != a[31];
            end
            6'h0a: c = {31'd0, $signed(a) < $signed(si)};
            6'h0b: c = {31'd0, a < si};
            6'h0c: c = a & zi;
            6'h0d: c = a | zi;
            6'h0e: c = a ^ zi;
            6'h04, 6'h05: c = a - b;
            6'h23, 6'h2b: c = a + si;
            default: ;
         endcase
      end
      zon = {c == 0, ov, c[31]};
   endfunction

   always_comb alu_fn(alu_instr, alu_a, alu_b,
                      alu_c, alu_zon, alu_hi, alu_lo);

   // architectural model: register file, HI/LO, flags, retire record
   logic [31:0] mrf [32];
   logic [31:0] mhi, mlo;
   logic [2:0]  mflags;
   int          stage;
   logic [31:0] e_instr, e_a, e_b, e_data, e_hi, e_lo;
   logic [2:0]  e_zon;
   logic [4:0]  e_dst;
   bit e_we, e_ac, e_dc, e_br, e_hl, e_fl;

   task automatic model_accept(input logic [31:0] ins);
      logic [31:0] a, b, c, hi, lo, d;
      logic [2:0]  z;
      logic [5:0]  op, fn;
      logic [4:0]  dst;
      bit ac, dc, br, hl, fl;
      a = mrf[ins[25:21]];
      b = mrf[ins[20:16]];
      alu_fn(ins, a, b, c, z, hi, lo);
      op = ins[31:26];
      fn = ins[5:0];
      dst = 0; d = c;
      ac = 0; dc = 0; br = 0; hl = 0; fl = 1;
      if (op == 0 && fn inside {6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
         dst = ins[15:11]; ac = 1; dc = 1;
      end else if (op == 0 && fn inside {6'h18, 6'h19}) begin
         hl = 1;
      end else if (op == 0 && fn inside {6'h1a, 6'h1b}) begin
         if (b != 0) hl = 1;
         else fl = 0;
      end else if (op == 0 && fn == 6'h10) begin
         dst = ins[15:11]; d = mhi; ac = 1; dc = 1; fl = 0;
      end else if (op == 0 && fn == 6'h12) begin
         dst = ins[15:11]; d = mlo; ac = 1; dc = 1; fl = 0;
      end else if (op inside {[6'h08:6'h0e]}) begin
         dst = ins[20:16]; ac = 1; dc = 1;
      end else if (op == 6'h04) begin
         br = z[2];
      end else if (op == 6'h05) begin
         br = !z[2];
      end else if (op inside {6'h23, 6'h2b}) begin
         dc = 1;
      end
      e_instr <= ins; e_a <= a; e_b <= b;
      e_data <= d; e_hi <= hi; e_lo <= lo; e_zon <= z;
      e_dst <= dst; e_we <= ac && dst != 0;
      e_ac <= ac; e_dc <= dc; e_br <= br;
      e_hl <= hl; e_fl <= fl;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) mrf[i] <= 0;
         mhi <= 0; mlo <= 0; mflags <= 0; stage <= 0;
      end else begin
         case (stage)
            0: if (instr_valid) begin
               model_accept(instr);
               stage <= 1;
            end else if (dbg_we && dbg_addr != 0) begin
               mrf[dbg_addr] <= dbg_wdata;
            end
            1: begin
               if (e_fl) mflags <= e_zon;
               stage <= 2;
            end
            default: begin
               if (e_we) mrf[e_dst] <= e_data;
               if (e_hl) begin
                  mhi <= e_hi; mlo <= e_lo;
               end
               stage <= 0;
            end
         endcase
      end
   end

   task automatic chk(input string nm,
                      input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #3;
      if (chk_en && !rst) begin
         chk("instr_ready", instr_ready, stage == 0);
         chk("wb_valid", wb_valid, stage == 2);
         chk("branch_taken", branch_taken, stage == 2 && e_br);
         chk("hi_q", hi_q, mhi);
         chk("lo_q", lo_q, mlo);
         chk("flags_q", flags_q, mflags);
         chk("dbg_rdata", dbg_rdata, mrf[dbg_addr]);
         if (stage != 0) begin
            chk("alu_instr", alu_instr, e_instr);
            chk("alu_a", alu_a, e_a);
            chk("alu_b", alu_b, e_b);
         end
         if (stage == 2) begin
            chk("wb_we", wb_we, e_we);
            if (e_ac) chk("wb_addr", wb_addr, e_dst);
            if (e_dc) chk("wb_data", wb_data, e_data);
         end
      end
   end

   function automatic logic [31:0] r_ins(
      input logic [5:0] f, input logic [4:0] s, t, d, sh);
      return {6'd0, s, t, d, sh, f};
   endfunction

   function automatic logic [31:0] i_ins(
      input logic [5:0] o, input logic [4:0] s, t,
      input logic [15:0] imm);
      return {o, s, t, imm};
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!instr_ready) begin
         failures++;
         $display("FAIL ready_timeout act=0 exp=1");
      end
   endtask

   task automatic issue(input logic [31:0] ins, input int hold);
      wait_ready();
      instr = ins;
      instr_valid = 1;
      @(negedge clk);
      repeat (hold) @(negedge clk);
      instr_valid = 0;
   endtask

   task automatic run(input logic [31:0] ins);
      issue(ins, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic dbgw(input logic [4:0] a,
                       input logic [31:0] d);
      dbg_we = 1; dbg_addr = a; dbg_wdata = d;
      @(negedge clk);
      dbg_we = 0;
   endtask

   task automatic dbgr(input string nm, input logic [4:0] a,
                       input logic [31:0] exp);
      dbg_addr = a;
      #1;
      chk(nm, dbg_rdata, exp);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 3))
         0: return 0;
         1: return $urandom_range(0, 15);
         2: return 32'h8000_0000 | $urandom_range(0, 15);
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0]  s, t, d, sh;
      logic [15:0] imm;
      logic [5:0]  f;
      s = 5'($urandom_range(0, 7));
      t = 5'($urandom_range(0, 7));
      d = 5'($urandom_range(0, 7));
      sh = 5'($urandom_range(0, 31));
      imm = 16'($urandom);
      case ($urandom_range(0, 29))
         0: f = 6'h20;  1: f = 6'h21;  2: f = 6'h22;
         3: f = 6'h23;  4: f = 6'h24;  5: f = 6'h25;
         6: f = 6'h26;  7: f = 6'h27;  8: f = 6'h2a;
         9: f = 6'h2b;  10: f = 6'h00; 11: f = 6'h02;
         12: f = 6'h03; 13: f = 6'h04; 14: f = 6'h06;
         15: f = 6'h07; 16: f = 6'h18; 17: f = 6'h19;
         18: f = 6'h1a; 19: f = 6'h1b; 20: f = 6'h10;
         21: f = 6'h12; 22: f = 6'h3f;
         23: return i_ins(6'($urandom_range(8, 14)), s, t, imm);
         24: return i_ins(6'h04, s, t, imm);
         25: return i_ins(6'h05, s, t, imm);
         26: return i_ins(6'h23, s, t, imm);
         27: return i_ins(6'h2b, s, t, imm);
         28: return i_ins(6'h3f, s, t, imm);
         default: return i_ins(6'h0d, s, t, imm);
      endcase
      return r_ins(f, s, t, d, sh);
   endfunction

   initial begin
      rst = 1; instr_valid = 0; instr = 0;
      dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      chk_en = 1;
      chk("rst_ready", instr_ready, 1);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_alu_instr", alu_instr, 0);
      chk("rst_hi", hi_q, 0);
      chk("rst_flags", flags_q, 0);

      run(i_ins(6'h0d, 0, 1, 16'h0005));
      run(i_ins(6'h0d, 0, 2, 16'h0003));
      issue(r_ins(6'h20, 1, 2, 3, 0), 0);
      @(negedge clk);
      chk("add_wb_valid", wb_valid, 1);
      chk("add_wb_we", wb_we, 1);
      chk("add_wb_addr", wb_addr, 3);
      chk("add_wb_data", wb_data, 8);
      @(negedge clk);
      dbgr("add_r3", 3, 8);

      dbgw(1, 32'h0001_0000);
      dbgw(2, 32'h0001_0000);
      issue(r_ins(6'h19, 1, 2, 0, 0), 0);
      @(negedge clk);
      chk("multu_we", wb_we, 0);
      @(negedge clk);
      chk("multu_hi", hi_q, 1);
      chk("multu_lo", lo_q, 0);
      run(r_ins(6'h10, 0, 0, 5, 0));
      run(r_ins(6'h12, 0, 0, 6, 0));
      dbgr("mfhi_r5", 5, 1);
      dbgr("mflo_r6", 6, 0);

      dbgw(1, 7);
      dbgw(2, 0);
      run(r_ins(6'h1b, 1, 2, 0, 0));
      chk("div0_hi", hi_q, 1);
      chk("div0_lo", lo_q, 0);
      chk("div0_flags", flags_q, 3'b100);

      dbgw(1, 9);
      dbgw(2, 9);
      issue(i_ins(6'h04, 1, 2, 16'h0010), 0);
      @(negedge clk);
      chk("beq_taken", branch_taken, 1);
      chk("beq_we", wb_we, 0);
      @(negedge clk);
      issue(i_ins(6'h05, 1, 2, 16'h0010), 0);
      @(negedge clk);
      chk("bne_taken", branch_taken, 0);
      @(negedge clk);
      dbgr("br_r1", 1, 9);

      dbgw(1, 1);
      dbgw(2, 2);
      issue(r_ins(6'h20, 1, 2, 0, 0), 0);
      @(negedge clk);
      chk("r0_wb_valid", wb_valid, 1);
      chk("r0_wb_we", wb_we, 0);
      chk("r0_wb_addr", wb_addr, 0);
      chk("r0_wb_data", wb_data, 3);
      @(negedge clk);
      dbgr("r0_read", 0, 0);

      instr = r_ins(6'h20, 1, 2, 3, 0);
      instr_valid = 1;
      @(negedge clk);
      rst = 1;
      instr_valid = 0;
      @(negedge clk);
      chk("rst_exec_wb_valid", wb_valid, 0);
      rst = 0;
      @(negedge clk);
      chk("rst2_ready", instr_ready, 1);
      chk("rst2_wb_valid", wb_valid, 0);
      chk("rst2_alu_a", alu_a, 0);
      chk("rst2_alu_instr", alu_instr, 0);
      chk("rst2_lo", lo_q, 0);
      dbgr("rst2_r3", 3, 0);
      dbgr("rst2_r1", 1, 0);

      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 2)) begin
            dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = 5'($urandom_range(0, 7));
            dbg_wdata = rnd_val();
            @(negedge clk);
         end
         dbg_we = ($urandom_range(0, 3) == 0);
         dbg_addr = 5'($urandom_range(0, 7));
         dbg_wdata = rnd_val();
         issue(rand_instr(), $urandom_range(0, 2));
      end
      dbg_we = 0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
Sequencing front end that drives the combinational MIPS ALU and retires its results. It takes in one instruction at a time through a valid/ready handshake and reads operands from an internal 32x32 register file. It drives the ALU instruction and operand inputs, then captures the ALU's c/zon/hi/lo outputs. It writes back to the register file or to the HI/LO registers, and reports branch outcome and retirement.

Parameters:
NREG, 32, number of general registers (index width 5)
W, 32, datapath width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
instr_valid  in  1  instruction offered
instr  in  32  MIPS instruction word
instr_ready  out  1  block can accept an instruction (IDLE only)
alu_instr  out  32  instruction word to ALU
alu_a  out  32  operand rs to ALU (gr1)
alu_b  out  32  operand rt to ALU (gr2)
alu_c  in  32  ALU result
alu_zon  in  3  ALU flags {zero, overflow, negative}
alu_hi  in  32  ALU HI result
alu_lo  in  32  ALU LO result
wb_valid  out  1  one-cycle pulse: instruction retired
wb_we  out  1  register-file write performed with this retire
wb_addr  out  5  destination register
wb_data  out  32  value written or computed
hi_q  out  32  architectural HI
lo_q  out  32  architectural LO
flags_q  out  3  last captured ALU flags
branch_taken  out  1  beq/bne outcome, valid with wb_valid
dbg_we  in  1  debug register write; honoured only in IDLE with no accept that cycle
dbg_addr  in  5  debug register index (write and read)
dbg_wdata  in  32  debug write data
dbg_rdata  out  32  combinational read of rf[dbg_addr]

Behaviour:
- Reset: state=IDLE; all rf entries, hi_q, lo_q, flags_q, alu_instr, alu_a, alu_b and wb_* are 0; branch_taken=0; instr_ready=1 in the first cycle after rst falls.
- r0 always reads 0. Writes to r0 are dropped: wb_we=0, while wb_addr and wb_data still report the target.
- FSM: IDLE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1.
  - On instr_valid at an edge: latch instr into alu_instr, rf[instr[25:21]] into alu_a, rf[instr[20:16]] into alu_b; go to EXEC.
  - instr_valid in EXEC/WB is ignored; the offerer must hold the instruction until ready.
- EXEC (1 cycle): alu_* outputs stable. At the closing edge, capture alu_c, alu_zon, alu_hi, alu_lo into result registers; go to WB.
- WB (1 cycle): wb_valid=1 and the rf/HI/LO update commits at the closing edge; go to IDLE. Retire latency is accept edge + 2 cycles; throughput is 1 instruction per 3 cycles.
- The next instruction accepted reads post-writeback values (the write commits before IDLE samples), so no bypass is required.
- Destination and write rules:
  - R-type ALU ops (add, addu, sub, subu, and, or, nor, xor, slt, sltu, sll, sllv, srl, srlv, sra, srav): rd=instr[15:11], wb_data=alu_c, wb_we=1.
  - I-type (addi, addiu, andi, ori, xori, slti, sltiu): rd=instr[20:16], wb_data=alu_c, wb_we=1.
  - mult, multu, divu, and div with nonzero divisor: hi_q=alu_hi, lo_q=alu_lo; wb_we=0.
  - div/divu with alu_b==0: HI/LO unchanged, wb_we=0, flags_q unchanged.
  - mfhi (func 010000) / mflo (func 010010): rd=instr[15:11], wb_data=hi_q / lo_q (pre-retire value); ALU outputs ignored; flags_q unchanged.
  - beq: branch_taken=alu_zon[2]. bne: branch_taken=~alu_zon[2]. wb_we=0.
  - lw/sw: wb_data=alu_c (address), wb_we=0.
  - Unrecognised opcode/func: retire with wb_we=0, branch_taken=0, no state change.
- flags_q is updated from alu_zon at the end of EXEC, except in the mfhi/mflo and divide-by-zero cases above.
- branch_taken is 0 outside WB.
- dbg_we in IDLE when instr_valid=0: rf[dbg_addr]=dbg_wdata at the edge. dbg_we in any other state, or together with an accept, is ignored.
- rst in any state: in-flight instruction discarded, no wb_valid, no partial rf/HI/LO write; rf cleared.

Test Plan:
- ori r1,r0,0x0005; ori r2,r0,0x0003; add r3,r1,r2 -> wb_valid 2 cycles after each accept; r3=8 (dbg_rdata), wb_we=1, wb_addr=3, instr_ready low for 2 cycles per instruction.
- dbg: r1=0x00010000, r2=0x00010000; multu r1,r2; mfhi r5; mflo r6 -> hi_q=1, lo_q=0, r5=1, r6=0, wb_we=0 on multu.
- dbg: r1=7, r2=0; divu r1,r2 preceded by hi_q=1, lo_q=0 -> hi_q/lo_q stay 1/0, wb_we=0, flags_q unchanged.
- r1=r2=9: beq r1,r2 -> branch_taken=1 in WB; bne r1,r2 -> branch_taken=0; rf unchanged.
- add r0,r1,r2 with r1=1, r2=2 -> wb_valid=1, wb_we=0, wb_addr=0, wb_data=3; dbg read r0=0.
- Assert rst during EXEC of add r3,r1,r2 -> no wb_valid, r3=0 and all outputs 0 after reset; instr_ready=1 the cycle after rst deasserts; instr_valid held in EXEC is not accepted twice.
